// File: rtl/input_4_aoi_circuit.sv
`default_nettype none
// ============================================================================
//  Module      : input_4_aoi_circuit
//  Description : 4-input AND-OR-INVERT cell, bitwise over WIDTH lanes.
//                y[i] = ~((a[i] & b[i]) | (c[i] & d[i]))
//                Optional output register; a valid flag travels with the data.
//
//  Parameters  : WIDTH    - lane count; all data ports are WIDTH bits
//                REG_OUT  - 1: y/out_valid registered (1-cycle latency)
//                           0: purely combinational (0 latency, no storage)
//
//  Ports       : clk       in   1      rising-edge clock
//                rst_n     in   1      synchronous active-low reset
//                in_valid  in   1      a/b/c/d carry a valid operand set
//                a, b      in   WIDTH  AND pair 0
//                c, d      in   WIDTH  AND pair 1
//                out_valid out  1      y holds the result of a valid set
//                y         out  WIDTH  AOI result per lane
//
//  Revision    : 1.0 - initial release
// ============================================================================
module input_4_aoi_circuit #(
    parameter int WIDTH   = 1,
    parameter int REG_OUT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    output logic             out_valid,
    output logic [WIDTH-1:0] y
);

    // Reset value of the registered output: AOI of all-zero operands.
    localparam logic [WIDTH-1:0] C_Y_RESET = {WIDTH{1'b1}};

    // Lanes are independent; plain bitwise operators keep it that way.
    logic [WIDTH-1:0] w_aoi;
    assign w_aoi = ~((a & b) | (c & d));

    generate
        if (REG_OUT != 0) begin : g_reg_out
            logic [WIDTH-1:0] r_y;
            logic             r_out_valid;

            // Data updates every cycle regardless of in_valid; consumers
            // qualify y with out_valid. Reset wins over in_valid.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_y         <= C_Y_RESET;
                    r_out_valid <= 1'b0;
                end else begin
                    r_y         <= w_aoi;
                    r_out_valid <= in_valid;
                end
            end

            assign y         = r_y;
            assign out_valid = r_out_valid;
        end else begin : g_comb_out
            // No storage: the clock is intentionally left without a load.
            logic w_unused_clk;
            assign w_unused_clk = clk;

            // Valid is suppressed while reset is asserted, even though
            // there is no state to clear.
            assign y         = w_aoi;
            assign out_valid = in_valid & rst_n;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_input_4_aoi_circuit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_input_4_aoi_circuit
//  Description : Directed self-checking bench for input_4_aoi_circuit.
//                Three instances: WIDTH=1/REG_OUT=1, WIDTH=4/REG_OUT=1,
//                WIDTH=1/REG_OUT=0.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_input_4_aoi_circuit;

    logic clk;
    logic rst_n;
    logic in_valid;

    // WIDTH=1, registered
    logic a1, b1, c1, d1, y1, ov1;
    // WIDTH=4, registered
    logic [3:0] a4, b4, c4, d4, y4;
    logic       ov4;
    // WIDTH=1, combinational
    logic ac, bc, cc, dc, yc, ovc;

    int n_checks;
    int n_fail;

    input_4_aoi_circuit #(.WIDTH(1), .REG_OUT(1)) u_dut_w1_reg (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .a(a1), .b(b1), .c(c1), .d(d1),
        .out_valid(ov1), .y(y1)
    );

    input_4_aoi_circuit #(.WIDTH(4), .REG_OUT(1)) u_dut_w4_reg (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .a(a4), .b(b4), .c(c4), .d(d4),
        .out_valid(ov4), .y(y4)
    );

    input_4_aoi_circuit #(.WIDTH(1), .REG_OUT(0)) u_dut_w1_comb (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .a(ac), .b(bc), .c(cc), .d(dc),
        .out_valid(ovc), .y(yc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive a 4-bit {a,b,c,d} code on the WIDTH=1 registered instance at the
    // falling edge, then check the result just after the next rising edge.
    task automatic apply1(input string tag, input logic [3:0] abcd, input logic v,
                          input logic exp_y, input logic exp_ov);
        @(negedge clk);
        {a1, b1, c1, d1} = abcd;
        in_valid = v;
        @(posedge clk);
        #1;
        check({tag, "_y"},  {31'd0, y1},  {31'd0, exp_y});
        check({tag, "_ov"}, {31'd0, ov1}, {31'd0, exp_ov});
    endtask

    function automatic logic golden(input logic [3:0] v);
        return ~((v[3] & v[2]) | (v[1] & v[0]));
    endfunction

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        in_valid = 1'b1;
        {a1, b1, c1, d1} = 4'b1111;
        a4 = 4'h0; b4 = 4'h0; c4 = 4'h0; d4 = 4'h0;
        {ac, bc, cc, dc} = 4'b1100;

        // Reset state; reset beats in_valid=1 with all-ones operands.
        @(posedge clk);
        #1;
        check("rst_y1",  {31'd0, y1},  32'd1);
        check("rst_ov1", {31'd0, ov1}, 32'd0);
        check("rst_y4",  {28'd0, y4},  32'hF);
        check("rst_ov4", {31'd0, ov4}, 32'd0);
        // Combinational instance: result is live, valid held low by reset.
        check("comb_rst_y",  {31'd0, yc},  32'd0);
        check("comb_rst_ov", {31'd0, ovc}, 32'd0);

        // Release reset; valid tracks in_valid.
        @(negedge clk);
        rst_n = 1'b1;
        a4 = 4'hF; b4 = 4'h3; c4 = 4'h4; d4 = 4'hC;
        {a1, b1, c1, d1} = 4'b0000;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("t1_0000_y",  {31'd0, y1},  32'd1);
        check("t1_0000_ov", {31'd0, ov1}, 32'd0);
        check("t5_w4_y",    {28'd0, y4},  32'h8);

        apply1("t1_0000v", 4'b0000, 1'b1, 1'b1, 1'b1);
        apply1("t1_0101",  4'b0101, 1'b1, 1'b1, 1'b1);
        apply1("t1_1010",  4'b1010, 1'b0, 1'b1, 1'b0);
        apply1("t1_0010",  4'b0010, 1'b1, 1'b1, 1'b1);
        apply1("t2_1100",  4'b1100, 1'b1, 1'b0, 1'b1);
        apply1("t2_1011",  4'b1011, 1'b1, 1'b0, 1'b1);
        apply1("t2_1111",  4'b1111, 1'b1, 1'b0, 1'b1);
        apply1("t2_0110",  4'b0110, 1'b1, 1'b1, 1'b1);

        // Back-to-back sweep of all 16 codes.
        for (int i = 0; i < 16; i++) begin
            logic [3:0] code;
            code = 4'(i);
            apply1($sformatf("t3_code%0d", i), code, 1'b1, golden(code), 1'b1);
        end

        // Mid-stream reset while driving 1111 valid.
        @(negedge clk);
        rst_n = 1'b0;
        {a1, b1, c1, d1} = 4'b1111;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        check("t4_rst_y",  {31'd0, y1},  32'd1);
        check("t4_rst_ov", {31'd0, ov1}, 32'd0);
        // Release between edges: outputs must not move until the clock.
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("t4_rel_hold_y",  {31'd0, y1},  32'd1);
        check("t4_rel_hold_ov", {31'd0, ov1}, 32'd0);
        @(posedge clk);
        #1;
        check("t4_first_y",  {31'd0, y1},  32'd0);
        check("t4_first_ov", {31'd0, ov1}, 32'd1);

        // Combinational instance: outputs follow inputs with no clock edge.
        @(negedge clk);
        {ac, bc, cc, dc} = 4'b0110;
        in_valid = 1'b1;
        #1;
        check("t6_0110_y",  {31'd0, yc},  32'd1);
        check("t6_0110_ov", {31'd0, ovc}, 32'd1);
        {ac, bc, cc, dc} = 4'b1100;
        #1;
        check("t6_1100_y", {31'd0, yc}, 32'd0);
        {ac, bc, cc, dc} = 4'b0011;
        in_valid = 1'b0;
        #1;
        check("t6_0011_y",  {31'd0, yc},  32'd0);
        check("t6_0011_ov", {31'd0, ovc}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
